// File: rtl/tx_uart.sv
// ----------------------------------------------------------------------------
// tx_uart -- 8N1-style UART transmitter with 16x oversampling ticks.
//
// Sends a start bit (0), NB_DATA data bits LSB first, then holds the line high
// for N_TICKS_TO_STOP ticks. One tick is N_CLKS_PER_TICK clocks; every start
// and data bit lasts 16 ticks.
//
// Ports:
//   i_clock        single clock, everything on its rising edge
//   i_reset        synchronous active-high reset
//   i_tx_start     request to send i_data (ignored while busy or in reset)
//   i_data         byte to transmit, captured when the frame is accepted
//   o_tx           serial line, registered, idle high
//   o_tx_done_tick one-clock pulse in the last clock of a frame
//   o_busy         high while a frame is in progress
// ----------------------------------------------------------------------------
module tx_uart #(
  parameter int NB_DATA         = 8,
  parameter int NB_STATE        = 2,
  parameter int NB_COUNT        = 4,
  parameter int NB_DATA_COUNT   = 3,
  parameter int N_TICKS_TO_STOP = 16,
  parameter int N_CLKS_PER_TICK = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_tx_done_tick,
  output logic               o_busy
);

  localparam int TICKS_PER_BIT = 16;
  localparam int NB_DIV        = (N_CLKS_PER_TICK > 1) ? $clog2(N_CLKS_PER_TICK) : 1;

  localparam logic [NB_COUNT-1:0]      BIT_TICK_LAST  = NB_COUNT'(TICKS_PER_BIT - 1);
  localparam logic [NB_COUNT-1:0]      STOP_TICK_LAST = NB_COUNT'(N_TICKS_TO_STOP - 1);
  localparam logic [NB_DATA_COUNT-1:0] DATA_BIT_LAST  = NB_DATA_COUNT'(NB_DATA - 1);
  localparam logic [NB_DIV-1:0]        DIV_LAST       = NB_DIV'(N_CLKS_PER_TICK - 1);

  typedef enum logic [NB_STATE-1:0] {
    IDLE  = NB_STATE'(0),
    START = NB_STATE'(1),
    DATA  = NB_STATE'(2),
    STOP  = NB_STATE'(3)
  } state_t;

  state_t                   state_r,    state_s;
  logic [NB_COUNT-1:0]      tick_cnt_r, tick_cnt_s;
  logic [NB_DATA_COUNT-1:0] bit_cnt_r,  bit_cnt_s;
  logic [NB_DATA-1:0]       shreg_r,    shreg_s;
  logic [NB_DIV-1:0]        div_cnt_r,  div_cnt_s;
  logic                     tick_s;
  logic                     tx_r,   tx_s;
  logic                     done_r, done_s;
  logic                     busy_r, busy_s;

  // The divider sits at its last count in the clock that carries a tick.
  assign tick_s = (div_cnt_r == DIV_LAST);

  // State, datapath and output registers; reset clears everything.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r    <= IDLE;
      tick_cnt_r <= '0;
      bit_cnt_r  <= '0;
      shreg_r    <= '0;
      div_cnt_r  <= '0;
      tx_r       <= 1'b1;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      tick_cnt_r <= tick_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shreg_r    <= shreg_s;
      div_cnt_r  <= div_cnt_s;
      tx_r       <= tx_s;
      done_r     <= done_s;
      busy_r     <= busy_s;
    end
  end

  // Next state plus next counter / shift-register values.
  always_comb begin
    state_s    = state_r;
    tick_cnt_s = tick_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    shreg_s    = shreg_r;
    if (state_r == IDLE) begin
      div_cnt_s = '0;
    end else if (tick_s) begin
      div_cnt_s = '0;
    end else begin
      div_cnt_s = div_cnt_r + 1'b1;
    end

    case (state_r)
      IDLE: begin
        if (i_tx_start) begin
          state_s    = START;
          tick_cnt_s = '0;
          bit_cnt_s  = '0;
          shreg_s    = i_data;
          div_cnt_s  = '0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (tick_s && (tick_cnt_r == BIT_TICK_LAST)) begin
          state_s    = DATA;
          tick_cnt_s = '0;
        end else if (tick_s) begin
          tick_cnt_s = tick_cnt_r + 1'b1;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (tick_s && (tick_cnt_r == BIT_TICK_LAST)) begin
          tick_cnt_s = '0;
          shreg_s    = {1'b0, shreg_r[NB_DATA-1:1]};
          if (bit_cnt_r == DATA_BIT_LAST) begin
            state_s   = STOP;
            bit_cnt_s = '0;
          end else begin
            bit_cnt_s = bit_cnt_r + 1'b1;
          end
        end else if (tick_s) begin
          tick_cnt_s = tick_cnt_r + 1'b1;
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (tick_s && (tick_cnt_r == STOP_TICK_LAST)) begin
          tick_cnt_s = '0;
          // A start request held through the final stop clock is taken as
          // if IDLE had been entered and left on this same edge, so
          // back-to-back frames carry no idle gap.
          if (i_tx_start) begin
            state_s   = START;
            bit_cnt_s = '0;
            shreg_s   = i_data;
            div_cnt_s = '0;
          end else begin
            state_s = IDLE;
          end
        end else if (tick_s) begin
          tick_cnt_s = tick_cnt_r + 1'b1;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s    = IDLE;
        tick_cnt_s = '0;
        bit_cnt_s  = '0;
        div_cnt_s  = '0;
      end
    endcase
  end

  // Output values for the next clock, derived from the next state so every
  // output leaves a flop. The done pulse is predicted one clock early: it is
  // high in the clock whose closing edge completes the last stop tick.
  always_comb begin
    tx_s = 1'b1;
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shreg_s[0];
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == STOP) && (tick_cnt_s == STOP_TICK_LAST) &&
             (div_cnt_s == DIV_LAST);
  end

  assign o_tx           = tx_r;
  assign o_tx_done_tick = done_r;
  assign o_busy         = busy_r;

endmodule

// File: tb/tb_tx_uart.sv
// ----------------------------------------------------------------------------
// tb_tx_uart -- scoreboard bench for tx_uart.
// Two instances: dut (1 clock per tick) and dut4 (4 clocks per tick).
// Stimulus pushes the expected byte of every frame that must complete; a
// negedge monitor follows o_busy/o_tx and, on each done pulse, pops the byte
// and compares the captured line waveform and frame length against a model
// that derives the line level from the bit-slot index.
// ----------------------------------------------------------------------------
module tb_tx_uart;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [7:0] data0, data1;
  logic       tx0, done0, busy0;
  logic       tx1, done1, busy1;

  always #5 clk = ~clk;

  tx_uart dut (
    .i_clock(clk), .i_reset(rst), .i_tx_start(start0), .i_data(data0),
    .o_tx(tx0), .o_tx_done_tick(done0), .o_busy(busy0)
  );

  tx_uart #(.N_CLKS_PER_TICK(4)) dut4 (
    .i_clock(clk), .i_reset(rst), .i_tx_start(start1), .i_data(data1),
    .o_tx(tx1), .o_tx_done_tick(done1), .o_busy(busy1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int mon_idx[2]     = '{0, 0};
  int mon_bad_idx[2] = '{-1, -1};
  int done_cnt[2]    = '{0, 0};
  int done_cyc[2]    = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  // Line level expected in clock idx of a frame (idx 0 = first clock after
  // acceptance): slot 0 start bit, slots 1..8 data LSB first, then stop.
  function automatic logic ref_level(input logic [7:0] d, input int idx, input int n);
    int slot;
    slot = idx / (16 * n);
    if (slot == 0) return 1'b0;
    else if (slot <= 8) return d[slot-1];
    else return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic mon_step(input int id, input logic tx, input logic busy,
                          input logic done, input int n);
    int len;
    logic [7:0] d;
    bit have;
    len  = 16 * 9 * n + 16 * n;
    have = 1'b0;
    d    = 8'h00;
    if (id == 0) begin
      if (exp_q0.size() > 0) begin have = 1'b1; d = exp_q0[0]; end
    end else begin
      if (exp_q1.size() > 0) begin have = 1'b1; d = exp_q1[0]; end
    end
    if (busy !== 1'b1) begin
      checks++;
      if (tx !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle_line[%0d] cyc %0d: tx=%b done=%b required tx=1 done=0",
                 id, cyc, tx, done);
      end
      // An aborted frame (reset) leaves partial samples behind; drop them.
      mon_idx[id]     = 0;
      mon_bad_idx[id] = -1;
    end else begin
      if (have && mon_idx[id] < len && mon_bad_idx[id] < 0 &&
          tx !== ref_level(d, mon_idx[id], n))
        mon_bad_idx[id] = mon_idx[id];
      mon_idx[id]++;
      if (done === 1'b1) begin
        done_cnt[id]++;
        done_cyc[id] = cyc;
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL unexpected_done[%0d] cyc %0d: done pulse with no frame expected", id, cyc);
        end else begin
          checks++;
          if (mon_idx[id] != len) begin
            errors++;
            $display("FAIL frame_len[%0d] data %h: got %0d clocks required %0d",
                     id, d, mon_idx[id], len);
          end
          checks++;
          if (mon_bad_idx[id] >= 0) begin
            errors++;
            $display("FAIL frame_wave[%0d] data %h clock %0d: got tx=%b required %b",
                     id, d, mon_bad_idx[id], ~ref_level(d, mon_bad_idx[id], n),
                     ref_level(d, mon_bad_idx[id], n));
          end
          if (id == 0) void'(exp_q0.pop_front());
          else void'(exp_q1.pop_front());
        end
        mon_idx[id]     = 0;
        mon_bad_idx[id] = -1;
      end
    end
  endtask

  // Monitor: sample both instances away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_step(0, tx0, busy0, done0, 1);
      mon_step(1, tx1, busy1, done1, 4);
    end
  end

  // Called at a negedge: one-clock start pulse, expected byte queued if the
  // frame is meant to complete.
  task automatic send(input int id, input logic [7:0] d, input bit expect_done);
    if (id == 0) begin
      data0 = d; start0 = 1'b1;
      if (expect_done) exp_q0.push_back(d);
    end else begin
      data1 = d; start1 = 1'b1;
      if (expect_done) exp_q1.push_back(d);
    end
    @(negedge clk);
    if (id == 0) start0 = 1'b0;
    else start1 = 1'b0;
  endtask

  task automatic wait_done(input int id, input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt[id] < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (done_cnt[id] < target) begin
      errors++;
      $display("FAIL done_timeout[%0d]: got %0d done pulses required %0d", id, done_cnt[id], target);
    end
  endtask

  initial begin
    int tgt;
    int t1;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_tx0", {31'd0, tx0}, 32'd1);
    chk("reset_busy0", {31'd0, busy0}, 32'd0);
    chk("reset_done0", {31'd0, done0}, 32'd0);
    chk("reset_tx1", {31'd0, tx1}, 32'd1);
    chk("reset_busy1", {31'd0, busy1}, 32'd0);
    chk("reset_done1", {31'd0, done1}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame.
    tgt = done_cnt[0] + 1;
    send(0, 8'hBD, 1'b1);
    wait_done(0, tgt, 400);
    @(negedge clk);

    // Random frames with data churn and ignored start requests while busy.
    for (int f = 0; f < 6; f++) begin
      logic [7:0] d;
      int gap;
      d   = 8'($urandom);
      gap = $urandom_range(1, 4);
      repeat (gap) @(negedge clk);
      tgt = done_cnt[0] + 1;
      send(0, d, 1'b1);
      for (int c = 0; c < 140; c++) begin
        data0  = 8'($urandom);
        start0 = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
      start0 = 1'b0;
      wait_done(0, tgt, 100);
      @(negedge clk);
    end

    // Busy rejection: 8'hFF requests near clocks 20 and 100 of a 5A frame.
    repeat (2) @(negedge clk);
    tgt = done_cnt[0] + 1;
    send(0, 8'h5A, 1'b1);
    repeat (18) @(negedge clk);
    data0 = 8'hFF; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (79) @(negedge clk);
    data0 = 8'hFF; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0, tgt, 200);
    repeat (30) @(negedge clk);
    chk("reject_busy_after", {31'd0, busy0}, 32'd0);
    chk("reject_done_count", done_cnt[0], tgt);

    // Back-to-back with start held high.
    exp_q0.push_back(8'h01);
    exp_q0.push_back(8'h80);
    data0 = 8'h01; start0 = 1'b1;
    @(negedge clk);
    data0 = 8'h80;
    tgt = done_cnt[0] + 1;
    wait_done(0, tgt, 200);
    t1 = done_cyc[0];
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0, tgt + 1, 200);
    chk("b2b_done_spacing", done_cyc[0] - t1, 160);
    repeat (5) @(negedge clk);

    // Mid-frame reset, with a start request during reset that must be ignored.
    tgt = done_cnt[0];
    send(0, 8'hC3, 1'b0);
    repeat (48) @(negedge clk);
    rst = 1'b1; start0 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start0 = 1'b0;
    chk("midrst_tx", {31'd0, tx0}, 32'd1);
    chk("midrst_busy", {31'd0, busy0}, 32'd0);
    repeat (200) @(negedge clk);
    chk("midrst_no_done", done_cnt[0], tgt);
    send(0, 8'h3C, 1'b1);
    wait_done(0, tgt + 1, 200);
    @(negedge clk);

    // Divider: four clocks per tick.
    send(1, 8'hA5, 1'b1);
    wait_done(1, 1, 800);
    @(negedge clk);
    send(1, 8'($urandom), 1'b1);
    wait_done(1, 2, 800);
    repeat (3) @(negedge clk);

    chk("queue0_empty", exp_q0.size(), 0);
    chk("queue1_empty", exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
